// File: rtl/fp_to_int_if.sv
// Valid/ready handshake bundle for the float-to-integer converter.
// The master side (producer/consumer) drives requests; the slave side is the converter.
interface fp_to_int_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_inexact
  );
endinterface

// File: rtl/fp_to_int.sv
// Iterative IEEE-754 single to signed 32-bit converter, truncating toward zero.
// The significand is denormalized into fixed point at most SHIFT_STEP bits per cycle.
module fp_to_int #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input logic         clk,
  input logic         rst_n,
  fp_to_int_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_SIGN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] K_NORM = 2'd0;
  localparam logic [1:0] K_ZERO = 2'd1;
  localparam logic [1:0] K_SAT  = 2'd2;
  localparam logic [1:0] K_NAN  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_sign;
  logic          r_left;
  logic [1:0]    r_kind;
  logic          r_ovf;
  logic          r_sticky;
  logic [DW-1:0] r_mag;
  logic [CW-1:0] r_n_rem;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic          r_out_ovf;
  logic          r_out_inexact;

  logic          w_accept;
  logic [7:0]    w_e;
  logic [22:0]   w_mant;
  logic [1:0]    w_kind;
  logic          w_ovf;
  logic          w_inexact;
  logic          w_left;
  logic [CW-1:0] w_n;
  logic [CW-1:0] w_m;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_mag_shift;
  logic [DW-1:0] w_result;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_e      = bus.in_data[30:23];
  assign w_mant   = bus.in_data[22:0];

  // Classify the incoming float and derive shift direction/count.
  always_comb begin
    w_kind    = K_NORM;
    w_ovf     = 1'b0;
    w_inexact = 1'b0;
    w_left    = 1'b0;
    w_n       = '0;
    if (w_e < 8'd127) begin
      w_kind    = K_ZERO;
      w_inexact = |bus.in_data[30:0];
    end else if (w_e == 8'hFF && |w_mant) begin
      w_kind = K_NAN;
      w_ovf  = 1'b1;
    end else if (bus.in_data == 32'hCF00_0000) begin
      w_kind = K_SAT;
    end else if (w_e >= 8'd158) begin
      w_kind = K_SAT;
      w_ovf  = 1'b1;
    end else if (w_e >= 8'd150) begin
      w_left = 1'b1;
      w_n    = CW'(w_e - 8'd150);
    end else begin
      w_n    = CW'(8'd150 - w_e);
    end
  end

  assign w_m         = (r_n_rem > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : r_n_rem;
  assign w_mask      = (DW'(1) << w_m) - DW'(1);
  assign w_mag_shift = r_left ? (r_mag << w_m) : (r_mag >> w_m);

  always_comb begin
    w_result = '0;
    case (r_kind)
      K_NORM:  w_result = r_sign ? (~r_mag + DW'(1)) : r_mag;
      K_SAT:   w_result = r_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      K_NAN:   w_result = 32'h7FFF_FFFF;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = (w_kind != K_NORM || w_n == '0) ? S_SIGN : S_ALIGN;
      end
      S_ALIGN: if (r_n_rem == w_m) w_state_nxt = S_SIGN;
      S_SIGN:  w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, shift in ALIGN, resolve sign and flags in SIGN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign        <= 1'b0;
      r_left        <= 1'b0;
      r_kind        <= K_NORM;
      r_ovf         <= 1'b0;
      r_sticky      <= 1'b0;
      r_mag         <= '0;
      r_n_rem       <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_ovf     <= 1'b0;
      r_out_inexact <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign   <= bus.in_data[31];
            r_mag    <= {8'b0, |w_e, w_mant};
            r_n_rem  <= w_n;
            r_left   <= w_left;
            r_kind   <= w_kind;
            r_ovf    <= w_ovf;
            r_sticky <= w_inexact;
          end
        end
        S_ALIGN: begin
          r_mag   <= w_mag_shift;
          r_n_rem <= r_n_rem - w_m;
          if (!r_left) r_sticky <= r_sticky | (|(r_mag & w_mask));
        end
        S_SIGN: begin
          r_out_data    <= w_result;
          r_out_ovf     <= r_ovf;
          r_out_inexact <= r_sticky;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_ovf     = r_out_ovf;
  assign bus.out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: directed floats with hand-computed integers,
// latency, backpressure hold and mid-operation reset.
module tb_fp_to_int;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
    logic        i;
  } exp_t;

  logic clk;
  logic rst_n;
  fp_to_int_if bus_if ();

  fp_to_int #(.SHIFT_STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare each delivered result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %h with no pending expectation", bus_if.out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(bus_if.out_data), 64'(e.d));
          check("out_ovf", 64'(bus_if.out_ovf), 64'(e.o));
          check("out_inexact", 64'(bus_if.out_inexact), 64'(e.i));
        end
      end
    end
  end

  // Issue one conversion, push its expectation, and check accept-to-valid latency.
  task automatic send(input logic [31:0] d, input logic [31:0] ed, input logic eo,
                      input logic ei, input int lat);
    int t;
    int cycles;
    t = 0;
    @(negedge clk);
    while (!bus_if.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_total++;
      $display("FAIL in_ready_timeout: in_ready stayed %b, expected 1", bus_if.in_ready);
    end
    sb.push_back('{d: ed, o: eo, i: ei});
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = $urandom;
    cycles = 0;
    while (!bus_if.out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check($sformatf("latency_%h", d), 64'(cycles), 64'(lat));
  endtask

  initial begin
    int t;
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({bus_if.in_ready, bus_if.out_valid, bus_if.out_data, bus_if.out_ovf, bus_if.out_inexact}),
          64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
    rst_n = 1'b1;

    send(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 7);
    send(32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 7);
    send(32'h4E80_0000, 32'h4000_0000, 1'b0, 1'b0, 3);
    send(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    send(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
    send(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
    send(32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    send(32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1);
    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
    send(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1);
    send(32'h4070_0000, 32'h0000_0003, 1'b0, 1'b1, 7);
    send(32'hC0E0_0000, 32'hFFFF_FFF9, 1'b0, 1'b0, 7);
    send(32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 1);
    send(32'h4B80_0000, 32'h0100_0000, 1'b0, 1'b0, 2);
    send(32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 7);

    // Backpressure: hold the result of 10.0f for ten cycles while new input is offered.
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    send(32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 6);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 32'h3F80_0000;
      check($sformatf("hold_cycle_%0d", c),
            64'({bus_if.in_ready, bus_if.out_valid, bus_if.out_data, bus_if.out_ovf, bus_if.out_inexact}),
            64'({1'b0, 1'b1, 32'h0000_000A, 1'b0, 1'b0}));
    end
    @(posedge clk);
    #1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handoff_state",
          64'({bus_if.in_ready, bus_if.out_valid, bus_if.out_data}),
          64'({1'b1, 1'b0, 32'h0000_000A}));
    send(32'h4000_0000, 32'h0000_0002, 1'b0, 1'b0, 7);

    // Reset three cycles into converting 1.0f: the in-flight result is dropped.
    @(posedge clk);
    #1;
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'h3F80_0000;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_align",
          64'({bus_if.in_ready, bus_if.out_valid, bus_if.out_data, bus_if.out_ovf, bus_if.out_inexact}),
          64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h42C8_0000, 32'h0000_0064, 1'b0, 1'b0, 6);

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drain", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
